// File: rtl/muldiv_seq.sv
// Sequential multiply/divide unit: one shift-add or restoring shift-subtract step per cycle.
// Fixed latency for every op; hi/lo/div_zero only change when an operation completes.
//
// state | meaning
// IDLE  | waiting for start
// CALC  | WIDTH iteration steps on operand magnitudes
// FIX   | sign correction, result registers written
// DONE  | one-cycle done pulse
module muldiv_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             flush,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               is_div, neg_lo, neg_hi, dz_op;
  logic [WIDTH-1:0]   acc_hi, acc_lo, opnd;

  logic               accept, sign_a, sign_b;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum, rem_sh;
  logic [WIDTH-1:0]   rem_diff;
  logic               rem_ge;
  logic [WIDTH-1:0]   nxt_hi, nxt_lo;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   res_hi, res_lo;

  assign accept = (state == S_IDLE) && start && !flush;
  assign sign_a = op[0] && a[WIDTH-1];
  assign sign_b = op[0] && b[WIDTH-1];
  assign a_mag  = sign_a ? -a : a;
  assign b_mag  = sign_b ? -b : b;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; flush wins over everything, including a same-cycle start
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (start) state_nxt = S_CALC;
        S_CALC: if (cnt == CNT_W'(1)) state_nxt = S_FIX;
        S_FIX:  state_nxt = S_DONE;
        S_DONE: state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Outputs decoded from state
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      S_CALC, S_FIX: busy = 1'b1;
      S_DONE:        done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  cnt <= '0;
    else if (accept)             cnt <= CNT_W'(WIDTH);
    else if (state == S_CALC)    cnt <= cnt - CNT_W'(1);
  end

  // Multiply: acc_lo holds |a| and is shifted out LSB-first while partial sums enter from the top.
  // Divide: acc_lo holds |a| shifting out MSB-first into the remainder, quotient bits shift in.
  always_comb begin
    mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    rem_sh   = {acc_hi, acc_lo[WIDTH-1]};
    rem_ge   = rem_sh >= {1'b0, opnd};
    rem_diff = rem_sh[WIDTH-1:0] - opnd;
    if (is_div) begin
      nxt_hi = rem_ge ? rem_diff : rem_sh[WIDTH-1:0];
      nxt_lo = {acc_lo[WIDTH-2:0], rem_ge};
    end else begin
      nxt_hi = mul_sum[WIDTH:1];
      nxt_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_div <= 1'b0;
      neg_lo <= 1'b0;
      neg_hi <= 1'b0;
      dz_op  <= 1'b0;
      acc_hi <= '0;
      acc_lo <= '0;
      opnd   <= '0;
    end else if (accept) begin
      is_div <= op[1];
      neg_lo <= sign_a ^ sign_b;
      neg_hi <= op[1] ? sign_a : (sign_a ^ sign_b);
      dz_op  <= op[1] && (b == '0);
      acc_hi <= '0;
      acc_lo <= a_mag;
      opnd   <= b_mag;
    end else if (state == S_CALC) begin
      acc_hi <= nxt_hi;
      acc_lo <= nxt_lo;
    end
  end

  // With b==0 the remainder path ends holding |a|; signing it by a's sign reproduces a exactly.
  always_comb begin
    prod     = {acc_hi, acc_lo};
    prod_fix = neg_lo ? -prod : prod;
    if (is_div) begin
      res_lo = dz_op ? '1 : (neg_lo ? -acc_lo : acc_lo);
      res_hi = neg_hi ? -acc_hi : acc_hi;
    end else begin
      res_hi = prod_fix[2*WIDTH-1:WIDTH];
      res_lo = prod_fix[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi       <= '0;
      lo       <= '0;
      div_zero <= 1'b0;
    end else if (state == S_FIX && !flush) begin
      hi       <= res_hi;
      lo       <= res_lo;
      div_zero <= dz_op;
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq (WIDTH=32): directed, random, flush, reset and back-to-back scenarios.
module tb_muldiv_seq;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    op = 2'd0;
  logic          flush = 1'b0;
  logic [W-1:0]  a = '0, b = '0;
  logic          busy, done, div_zero;
  logic [W-1:0]  hi, lo;

  int checks = 0;
  int failures = 0;

  muldiv_seq #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .flush(flush),
    .a(a), .b(b), .busy(busy), .done(done), .hi(hi), .lo(lo), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Reference: plain arithmetic on the operand values
  task automatic ref_model(input logic [1:0] o, input logic [W-1:0] x, y,
                           output logic [W-1:0] eh, el, output logic edz);
    logic [63:0] p;
    longint sx, sy, q, r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    edz = 1'b0;
    eh = '0;
    el = '0;
    case (o)
      2'd0: begin p = {32'd0, x} * {32'd0, y}; eh = p[63:32]; el = p[31:0]; end
      2'd1: begin p = 64'(sx * sy); eh = p[63:32]; el = p[31:0]; end
      2'd2: begin
        if (y == 0) begin el = '1; eh = x; edz = 1'b1; end
        else begin el = x / y; eh = x % y; end
      end
      default: begin
        if (y == 0) begin el = '1; eh = x; edz = 1'b1; end
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin el = x; eh = '0; end
        else begin q = sx / sy; r = sx % sy; el = q[31:0]; eh = r[31:0]; end
      end
    endcase
  endtask

  function automatic logic [W-1:0] rand_opnd();
    logic [W-1:0] v;
    case ($urandom_range(0, 7))
      0: v = '0;
      1: v = 32'hFFFF_FFFF;
      2: v = 32'h8000_0000;
      3: v = 32'($urandom_range(0, 15));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  // Issue one op, scramble inputs after the sampling edge, wait (bounded) for done
  task automatic do_op(input logic [1:0] o, input logic [W-1:0] x, y,
                       output int lat, output logic [W-1:0] rh, rl, output logic rdz);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
    while (done !== 1'b1 && lat < 200) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    rh = hi; rl = lo; rdz = div_zero;
  endtask

  task automatic test_reset();
    #3;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (hi !== '0) begin failures++; $display("FAIL reset_hi got=%h exp=0", hi); end
    checks++; if (lo !== '0) begin failures++; $display("FAIL reset_lo got=%h exp=0", lo); end
    checks++; if (div_zero !== 1'b0) begin failures++; $display("FAIL reset_dz got=%b exp=0", div_zero); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_directed();
    logic [1:0]   ops[6] = '{2'd0, 2'd1, 2'd3, 2'd3, 2'd2, 2'd0};
    logic [W-1:0] xs[6]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFF9, 32'h8000_0000, 32'h0000_002A, 32'h3};
    logic [W-1:0] ys[6]  = '{32'hFFFF_FFFF, 32'h3, 32'h2, 32'hFFFF_FFFF, 32'h0, 32'h5};
    logic [W-1:0] ehs[6] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0000_002A, 32'h0};
    logic [W-1:0] els[6] = '{32'h0000_0001, 32'hFFFF_FFFA, 32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hF};
    logic         edz[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    int lat;
    logic [W-1:0] rh, rl;
    logic rdz;
    for (int i = 0; i < 6; i++) begin
      do_op(ops[i], xs[i], ys[i], lat, rh, rl, rdz);
      checks++; if (lat != W + 2) begin failures++; $display("FAIL dir_latency case=%0d got=%0d exp=%0d", i, lat, W + 2); end
      checks++; if (rh !== ehs[i]) begin failures++; $display("FAIL dir_hi case=%0d got=%h exp=%h", i, rh, ehs[i]); end
      checks++; if (rl !== els[i]) begin failures++; $display("FAIL dir_lo case=%0d got=%h exp=%h", i, rl, els[i]); end
      checks++; if (rdz !== edz[i]) begin failures++; $display("FAIL dir_dz case=%0d got=%b exp=%b", i, rdz, edz[i]); end
    end
  endtask

  task automatic test_random();
    int lat;
    logic [1:0] o;
    logic [W-1:0] x, y, rh, rl, eh, el;
    logic rdz, edz;
    for (int i = 0; i < 60; i++) begin
      o = 2'($urandom);
      x = rand_opnd();
      y = rand_opnd();
      ref_model(o, x, y, eh, el, edz);
      do_op(o, x, y, lat, rh, rl, rdz);
      checks++; if (lat != W + 2) begin failures++; $display("FAIL rand_latency op=%0d got=%0d exp=%0d", o, lat, W + 2); end
      checks++; if (rh !== eh) begin failures++; $display("FAIL rand_hi op=%0d a=%h b=%h got=%h exp=%h", o, x, y, rh, eh); end
      checks++; if (rl !== el) begin failures++; $display("FAIL rand_lo op=%0d a=%h b=%h got=%h exp=%h", o, x, y, rl, el); end
      checks++; if (rdz !== edz) begin failures++; $display("FAIL rand_dz op=%0d a=%h b=%h got=%b exp=%b", o, x, y, rdz, edz); end
    end
  endtask

  task automatic test_flush();
    int lat;
    logic [W-1:0] rh, rl;
    logic rdz;
    bit seen_done;
    // Known prior result that must survive the flushed divide
    do_op(2'd0, 32'h1234_5678, 32'h10, lat, rh, rl, rdz);
    @(negedge clk);
    start = 1'b1; op = 2'd2; a = 32'd100; b = 32'd7;
    @(posedge clk);
    for (int k = 1; k < 10; k++) begin
      @(negedge clk);
      op = 2'($urandom); a = $urandom; b = $urandom;
      if (k == 5) begin
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL flush_busy_calc got=%b exp=1", busy); end
        checks++; if (hi !== 32'h1 || lo !== 32'h2345_6780) begin
          failures++; $display("FAIL flush_hold_calc got=%h_%h exp=00000001_23456780", hi, lo); end
      end
      @(posedge clk);
    end
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL flush_busy_after got=%b exp=0", busy); end
    flush = 1'b0; start = 1'b0;
    seen_done = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen_done = 1;
    end
    checks++; if (seen_done) begin failures++; $display("FAIL flush_no_done got=activity exp=idle"); end
    checks++; if (hi !== 32'h1) begin failures++; $display("FAIL flush_hi got=%h exp=00000001", hi); end
    checks++; if (lo !== 32'h2345_6780) begin failures++; $display("FAIL flush_lo got=%h exp=23456780", lo); end
    checks++; if (div_zero !== 1'b0) begin failures++; $display("FAIL flush_dz got=%b exp=0", div_zero); end
  endtask

  task automatic test_reset_mid();
    int lat;
    logic [W-1:0] x, y, rh, rl, eh, el;
    logic rdz, edz;
    bit seen_done;
    @(negedge clk);
    start = 1'b1; op = 2'd0; a = 32'hDEAD_BEEF; b = 32'h1234_5678;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL rstmid_ctrl got=%b%b exp=00", busy, done); end
    checks++; if (hi !== '0 || lo !== '0) begin failures++; $display("FAIL rstmid_data got=%h_%h exp=0_0", hi, lo); end
    checks++; if (div_zero !== 1'b0) begin failures++; $display("FAIL rstmid_dz got=%b exp=0", div_zero); end
    @(negedge clk);
    rst_n = 1'b1;
    seen_done = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done === 1'b1) seen_done = 1;
    end
    checks++; if (seen_done) begin failures++; $display("FAIL rstmid_no_done got=done exp=none"); end
    x = $urandom; y = $urandom;
    ref_model(2'd1, x, y, eh, el, edz);
    do_op(2'd1, x, y, lat, rh, rl, rdz);
    checks++; if (lat != W + 2) begin failures++; $display("FAIL rstmid_latency got=%0d exp=%0d", lat, W + 2); end
    checks++; if (rh !== eh || rl !== el) begin failures++; $display("FAIL rstmid_result got=%h_%h exp=%h_%h", rh, rl, eh, el); end
  endtask

  task automatic test_back_to_back();
    int lat, gap;
    logic [1:0] o1, o2;
    logic [W-1:0] x1, y1, x2, y2, rh, rl, eh, el;
    logic rdz, edz;
    for (int i = 0; i < 4; i++) begin
      o1 = 2'($urandom); x1 = rand_opnd(); y1 = rand_opnd();
      o2 = 2'($urandom); x2 = rand_opnd(); y2 = rand_opnd();
      ref_model(o1, x1, y1, eh, el, edz);
      do_op(o1, x1, y1, lat, rh, rl, rdz);
      checks++; if (rh !== eh || rl !== el || rdz !== edz) begin
        failures++; $display("FAIL b2b_first got=%h_%h_%b exp=%h_%h_%b", rh, rl, rdz, eh, el, edz); end
      // Start raised during DONE and held well into CALC with changing operands
      start = 1'b1; op = o2; a = x2; b = y2;
      gap = 0;
      do begin
        @(posedge clk);
        gap++;
        @(negedge clk);
        if (gap >= 2) begin op = 2'($urandom); a = $urandom; b = $urandom; end
        if (gap == 12) start = 1'b0;
      end while (done !== 1'b1 && gap < 200);
      start = 1'b0;
      ref_model(o2, x2, y2, eh, el, edz);
      checks++; if (gap != W + 3) begin failures++; $display("FAIL b2b_interval got=%0d exp=%0d", gap, W + 3); end
      checks++; if (hi !== eh || lo !== el || div_zero !== edz) begin
        failures++; $display("FAIL b2b_second got=%h_%h_%b exp=%h_%h_%b", hi, lo, div_zero, eh, el, edz); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the operand width in bits (legal values 8..64, even).
REQ-002 SHALL have parameter CNT_W, default 6, giving the iteration counter width; it must satisfy 2^CNT_W > WIDTH.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: operation request, sampled only in IDLE.
REQ-006 SHALL have port op, input, 2 bits: 00 MULTU, 01 MULT (signed), 10 DIVU, 11 DIV (signed).
REQ-007 SHALL have port flush, input, 1 bit: synchronous abort of any operation in flight.
REQ-008 SHALL have ports a and b, input, WIDTH bits each: operands (multiplicand/dividend a, multiplier/divisor b).
REQ-009 SHALL have port busy, output, 1 bit: high while in CALC or FIX.
REQ-010 SHALL have port done, output, 1 bit: a one-cycle pulse, high only in DONE.
REQ-011 SHALL have port hi, output, WIDTH bits: product upper half / remainder.
REQ-012 SHALL have port lo, output, WIDTH bits: product lower half / quotient.
REQ-013 SHALL have port div_zero, output, 1 bit: the last completed operation was a divide with b==0.

Function
REQ-014 SHALL implement FSM states IDLE, CALC, FIX, DONE.
REQ-015 SHALL take transition IDLE->CALC on start==1; op, a and b are latched on that edge, the counter is loaded with WIDTH, and signed operands are converted to magnitudes with their signs recorded.
REQ-016 SHALL stay in CALC for exactly WIDTH cycles, performing one shift-add (multiply) or one restoring shift-subtract (divide) step per cycle, then go CALC->FIX.
REQ-017 SHALL, in FIX (1 cycle), apply sign correction, write hi/lo/div_zero, then go FIX->DONE.
REQ-018 SHALL go DONE->IDLE unconditionally after one cycle; start is ignored in CALC, FIX and DONE (no queueing).
REQ-019 SHALL assert done exactly WIDTH+2 cycles after the edge that sampled start, for every op including divide by zero; latency is fixed.
REQ-020 SHALL produce the full 2*WIDTH-bit product {hi,lo} for MULTU (unsigned) and MULT (two's complement).
REQ-021 SHALL, for DIVU/DIV, give lo = quotient and hi = remainder; signed quotient truncates toward zero and the signed remainder takes the sign of a.
REQ-022 SHALL, for signed overflow (a = most-negative, b = all ones), give lo = a and hi = 0.
REQ-023 SHALL, for divide by zero (any divide op, b==0), give lo = all ones and hi = a, with div_zero = 1; no sign correction is applied.
REQ-024 SHALL set div_zero = 0 on every multiply and every divide with b != 0.
REQ-025 SHALL hold hi, lo and div_zero stable from FIX until the next FIX; they are not disturbed by a new start, by CALC, or by flush.
REQ-026 SHALL, with flush==1 in any state, go to IDLE on the next edge: no done pulse, outputs unchanged; flush has priority over start in the same cycle, so that start is dropped.
REQ-027 SHALL treat flush in DONE as suppressing nothing, since done was already high that cycle.
REQ-028 SHALL support back-to-back operation: start asserted in the first IDLE cycle after DONE is accepted, giving a minimum issue interval of WIDTH+3 cycles.

Reset
REQ-029 SHALL, on rst_n low, immediately and asynchronously force state=IDLE, busy=0, done=0, hi=0, lo=0, div_zero=0, and clear the counter and internal registers.
REQ-030 SHALL, on reset mid-operation, abandon the operation with no done; the first start after rst_n rises is accepted normally.
REQ-031 SHALL NOT accept start while rst_n is low; release of rst_n is synchronised by the environment.

Verification
REQ-032 SHALL be verified, with WIDTH=32, by: MULTU a=FFFFFFFF b=FFFFFFFF -> done at start+34 with hi=FFFFFFFE, lo=00000001, div_zero=0.
REQ-033 SHALL be verified by: MULT a=FFFFFFFE (-2), b=00000003 -> hi=FFFFFFFF, lo=FFFFFFFA.
REQ-034 SHALL be verified by: DIV a=FFFFFFF9 (-7), b=00000002 -> lo=FFFFFFFD (-3), hi=FFFFFFFF (-1); and DIV a=80000000, b=FFFFFFFF -> lo=80000000, hi=0.
REQ-035 SHALL be verified by: DIVU a=0000002A, b=0 -> done at start+34, lo=FFFFFFFF, hi=0000002A, div_zero=1; a following MULTU 3*5 -> hi=0, lo=0000000F, div_zero=0.
REQ-036 SHALL be verified by: flush at start+10 during DIVU 100/7 -> no done, busy low next cycle, hi/lo retain previous values; start held during CALC is ignored.
REQ-037 SHALL be verified by: rst_n pulsed low at start+5 -> all outputs 0 immediately; and back-to-back start at DONE+1 -> second done exactly 35 cycles after the first.
